// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

   // Loader FSM state encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned LANE_W         = 2;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: each pushed byte fills the next lane.
module imem_word_packer
   import imem_loader_pkg::*;
#(
   parameter int unsigned BITSIZE = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_push,
   input  logic [7:0]         i_data,
   output logic               o_word_full,
   output logic [BITSIZE-1:0] o_word
);

   logic [LANE_W-1:0]  r_byte_idx;
   logic [BITSIZE-1:0] r_word;

   // Lane register and lane counter; the counter wraps to 0 after the last lane
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_word     <= '0;
         r_byte_idx <= '0;
      end else if (i_clear) begin
         r_word     <= '0;
         r_byte_idx <= '0;
      end else if (i_push) begin
         r_word[{r_byte_idx, 3'b000} +: 8] <= i_data;
         r_byte_idx                        <= r_byte_idx + LANE_W'(1);
      end
   end

   // Flags the push that completes the word, so the FSM can move to WRITE
   always_comb begin
      o_word_full = i_push && (r_byte_idx == LANE_W'(BYTES_PER_WORD - 1));
      o_word      = r_word;
   end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory words and releases the CPU when loaded.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned BITSIZE    = 32,
   parameter int unsigned REGSIZE    = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH:0]   i_word_count,
   input  logic                  i_in_valid,
   input  logic [7:0]            i_in_data,
   output logic                  o_in_ready,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [BITSIZE-1:0]    o_mem_wdata,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic                  o_cpu_hold
);

   localparam int unsigned CW = ADDR_WIDTH + 1;

   state_e                r_state, w_state_nxt;
   logic [CW-1:0]         r_count, w_count_nxt;
   logic [ADDR_WIDTH-1:0] r_word_idx, w_word_idx_nxt;
   logic                  r_error, w_error_nxt;
   logic                  w_clear;
   logic                  w_push;
   logic                  w_word_full;
   logic [BITSIZE-1:0]    w_word;

   assign w_push = (r_state == RECV) && i_in_valid;

   imem_word_packer #(
      .BITSIZE (BITSIZE)
   ) u_packer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (w_clear),
      .i_push      (w_push),
      .i_data      (i_in_data),
      .o_word_full (w_word_full),
      .o_word      (w_word)
   );

   // State, word counter and sticky error registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_word_idx <= '0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_word_idx <= w_word_idx_nxt;
         r_error    <= w_error_nxt;
      end
   end

   // Next-state logic; start is only honoured in IDLE and DONE
   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_word_idx_nxt = r_word_idx;
      w_error_nxt    = r_error;
      w_clear        = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (i_start) begin
               if (i_word_count > CW'(REGSIZE)) begin
                  w_error_nxt = 1'b1;
                  w_state_nxt = IDLE;
               end else if (i_word_count == '0) begin
                  w_error_nxt = 1'b0;
                  w_state_nxt = DONE;
               end else begin
                  w_count_nxt    = i_word_count;
                  w_word_idx_nxt = '0;
                  w_clear        = 1'b1;
                  w_error_nxt    = 1'b0;
                  w_state_nxt    = RECV;
               end
            end
         end
         RECV: begin
            if (w_word_full) begin
               w_state_nxt = WRITE;
            end
         end
         WRITE: begin
            if ({1'b0, r_word_idx} == r_count - CW'(1)) begin
               w_state_nxt = DONE;
            end else begin
               w_word_idx_nxt = r_word_idx + ADDR_WIDTH'(1);
               w_state_nxt    = RECV;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs depend only on registered state
   always_comb begin
      o_in_ready  = (r_state == RECV);
      o_mem_we    = (r_state == WRITE);
      o_mem_addr  = r_word_idx;
      o_mem_wdata = (r_state == WRITE) ? w_word : '0;
      o_busy      = (r_state == RECV) || (r_state == WRITE);
      o_done      = (r_state == DONE);
      o_error     = r_error;
      o_cpu_hold  = (r_state != DONE);
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader with a queue-based write model.
module tb_imem_loader;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [5:0]  i_word_count = '0;
   logic        i_in_valid = 1'b0;
   logic [7:0]  i_in_data = '0;
   logic        o_in_ready, o_mem_we, o_busy, o_done, o_error, o_cpu_hold;
   logic [4:0]  o_mem_addr;
   logic [31:0] o_mem_wdata;

   imem_loader #(
      .BITSIZE    (32),
      .REGSIZE    (32),
      .ADDR_WIDTH (5)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_word_count (i_word_count),
      .i_in_valid   (i_in_valid),
      .i_in_data    (i_in_data),
      .o_in_ready   (o_in_ready),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_error      (o_error),
      .o_cpu_hold   (o_cpu_hold)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: expected (addr, word) writes in order
   logic [4:0]  exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [7:0]  bytes_q[$];
   int          we_cnt = 0;
   int          last_addr = -1;

   always @(negedge i_clk) begin
      if (!i_rst && o_mem_we) begin
         we_cnt++;
         last_addr = int'(o_mem_addr);
         if (exp_addr_q.size() == 0) begin
            check_val("unexpected_write", 32'd1, 32'd0);
         end else begin
            check_val("write_addr", {27'd0, o_mem_addr}, {27'd0, exp_addr_q.pop_front()});
            check_val("write_data", o_mem_wdata, exp_data_q.pop_front());
         end
      end
   end

   task automatic fill_random(input int n);
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
   endtask

   task automatic pulse_start(input int count);
      @(negedge i_clk);
      i_start      = 1'b1;
      i_word_count = 6'(count);
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   // Starts a load of 'count' words and streams the first n_bytes of bytes_q
   task automatic run_load(input int count, input bit gaps, input int n_bytes, input int inject_at);
      int  idx;
      int  budget;
      bit  pending;
      bit  fire;
      bit  v;
      for (int k = 0; k < n_bytes / 4; k++) begin
         exp_addr_q.push_back(5'(k));
         exp_data_q.push_back({bytes_q[4*k+3], bytes_q[4*k+2], bytes_q[4*k+1], bytes_q[4*k]});
      end
      pulse_start(count);
      check_val("start_busy", {31'd0, o_busy}, 32'd1);
      check_val("start_error", {31'd0, o_error}, 32'd0);
      check_val("start_hold", {31'd0, o_cpu_hold}, 32'd1);
      idx     = 0;
      budget  = 0;
      pending = 1'b0;
      while (idx < n_bytes && budget < 5000) begin
         check_val("we_timing", {31'd0, o_mem_we}, {31'd0, pending});
         check_val("ready_timing", {31'd0, o_in_ready}, {31'd0, !pending});
         v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         i_in_valid = v;
         i_in_data  = bytes_q[idx];
         if (idx == inject_at) begin
            i_start      = 1'b1;
            i_word_count = 6'd1;
         end
         fire = v && o_in_ready;
         @(posedge i_clk);
         pending = 1'b0;
         if (fire) begin
            idx++;
            if (idx % 4 == 0) pending = 1'b1;
         end
         @(negedge i_clk);
         i_start    = 1'b0;
         i_in_valid = 1'b0;
         budget++;
      end
      if (budget >= 5000) check_val("load_timeout", 32'd0, 32'd1);
      if (pending) begin
         check_val("we_last", {31'd0, o_mem_we}, 32'd1);
         check_val("ready_in_write", {31'd0, o_in_ready}, 32'd0);
      end
   endtask

   task automatic check_done(input string tag);
      @(negedge i_clk);
      check_val({tag, "_done"}, {31'd0, o_done}, 32'd1);
      check_val({tag, "_hold"}, {31'd0, o_cpu_hold}, 32'd0);
      check_val({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      check_val({tag, "_ready"}, {31'd0, o_in_ready}, 32'd0);
      check_val({tag, "_pending"}, exp_addr_q.size(), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_ready"}, {31'd0, o_in_ready}, 32'd0);
      check_val({tag, "_we"}, {31'd0, o_mem_we}, 32'd0);
      check_val({tag, "_addr"}, {27'd0, o_mem_addr}, 32'd0);
      check_val({tag, "_wdata"}, o_mem_wdata, 32'd0);
      check_val({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      check_val({tag, "_done"}, {31'd0, o_done}, 32'd0);
      check_val({tag, "_error"}, {31'd0, o_error}, 32'd0);
      check_val({tag, "_hold"}, {31'd0, o_cpu_hold}, 32'd1);
   endtask

   initial begin
      int we_before;
      logic [7:0] basic [8] = '{8'h73, 8'h81, 8'h20, 8'h00, 8'hF3, 8'h91, 8'h20, 8'h00};

      #3;
      check_reset_vals("reset");
      #10 i_rst = 1'b0;

      // Basic load, back-to-back bytes
      bytes_q.delete();
      foreach (basic[i]) bytes_q.push_back(basic[i]);
      check_val("basic_word0", {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]}, 32'h0020_8173);
      we_before = we_cnt;
      run_load(2, 1'b0, 8, -1);
      check_done("basic");
      check_val("basic_we_cycles", we_cnt - we_before, 32'd2);

      // Source keeps offering bytes after done: none may be accepted
      i_in_valid = 1'b1;
      repeat (3) begin
         @(negedge i_clk);
         check_val("post_done_ready", {31'd0, o_in_ready}, 32'd0);
      end
      i_in_valid = 1'b0;

      // Same stream with valid gaps
      we_before = we_cnt;
      run_load(2, 1'b1, 8, -1);
      check_done("gaps");
      check_val("gaps_we_cycles", we_cnt - we_before, 32'd2);

      // Zero-count load goes straight to DONE
      we_before = we_cnt;
      pulse_start(0);
      check_val("zero_done", {31'd0, o_done}, 32'd1);
      check_val("zero_ready", {31'd0, o_in_ready}, 32'd0);
      check_val("zero_hold", {31'd0, o_cpu_hold}, 32'd0);
      @(negedge i_clk);
      check_val("zero_no_we", we_cnt - we_before, 32'd0);

      // Overflow rejected from DONE, then again from IDLE
      pulse_start(33);
      check_val("ovf_error", {31'd0, o_error}, 32'd1);
      check_val("ovf_done", {31'd0, o_done}, 32'd0);
      check_val("ovf_hold", {31'd0, o_cpu_hold}, 32'd1);
      check_val("ovf_busy", {31'd0, o_busy}, 32'd0);
      pulse_start(63);
      check_val("ovf2_error", {31'd0, o_error}, 32'd1);
      check_val("ovf2_ready", {31'd0, o_in_ready}, 32'd0);
      check_val("ovf_no_we", we_cnt - we_before, 32'd0);
      fill_random(4);
      run_load(1, 1'b1, 4, -1);
      check_done("after_ovf");
      check_val("after_ovf_error", {31'd0, o_error}, 32'd0);

      // Asynchronous reset after two bytes of the second word
      fill_random(8);
      run_load(2, 1'b0, 6, -1);
      #2 i_rst = 1'b1;
      #1 check_reset_vals("midreset");
      #1 i_rst = 1'b0;
      check_val("midreset_pending", exp_addr_q.size(), 32'd0);
      bytes_q.delete();
      bytes_q.push_back(8'h13);
      repeat (3) bytes_q.push_back(8'h00);
      run_load(1, 1'b0, 4, -1);
      check_done("after_reset");

      // Random short loads with gaps
      for (int t = 0; t < 4; t++) begin
         int cnt;
         cnt = $urandom_range(1, 8);
         fill_random(cnt * 4);
         run_load(cnt, 1'b1, cnt * 4, -1);
         check_done("rand");
      end

      // Full depth with an ignored start mid-load
      fill_random(128);
      we_before = we_cnt;
      run_load(32, 1'b1, 128, 50);
      check_done("full");
      check_val("full_we_cycles", we_cnt - we_before, 32'd32);
      check_val("full_last_addr", last_addr, 32'd31);

      repeat (2) @(negedge i_clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes, little-endian, into a 32-bit instruction word.
- Writes each word to consecutive word addresses of the instruction memory, starting at address 0.
- Holds the CPU core stalled (cpu_hold) until the program image is fully loaded.

Parameters:
- BITSIZE, 32, instruction word width; fixed at 4 bytes.
- REGSIZE, 32, instruction memory depth in words.
- ADDR_WIDTH, 5, word address width; must equal clog2(REGSIZE).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load.
- word_count  input  ADDR_WIDTH+1  number of words to load; sampled only in the cycle start is accepted.
- in_valid  input  1  in_data carries a valid byte.
- in_data  input  8  program byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_wdata  output  BITSIZE  word to be written.
- busy  output  1  load in progress.
- done  output  1  last load completed; sticky.
- error  output  1  last start was rejected; sticky.
- cpu_hold  output  1  keep the CPU core stalled.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1.
- Reset is effective immediately and asynchronously, including mid-load. Words already written are not rolled back; the partial byte assembly is discarded.
- States: IDLE, RECV, WRITE, DONE. State is registered; all outputs are registered or derived only from state.
- IDLE:
  - start=1 with word_count > REGSIZE -> error=1, stay in IDLE, no writes.
  - start=1 with word_count=0 -> go to DONE, no writes.
  - start=1 otherwise -> latch word_count; clear word_idx, byte_idx, error and done; go to RECV.
- RECV:
  - in_ready=1, busy=1.
  - A byte is accepted when in_valid and in_ready are both 1. It goes into byte lane byte_idx (lane 0 = bits 7:0) and byte_idx increments.
  - in_valid gaps are allowed and stall the loader with no side effects.
  - On acceptance of the 4th byte -> go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word_idx, mem_wdata=assembled word, in_ready=0.
  - mem_we therefore asserts the cycle after the 4th byte handshake.
  - If word_idx == count-1 -> go to DONE. Otherwise word_idx increments and the state returns to RECV.
- DONE:
  - done=1, busy=0, cpu_hold=0, in_ready=0.
  - start behaves as in IDLE. A rejected start (word_count > REGSIZE) also sets error, clears done, and sends the state to IDLE with cpu_hold=1.
- start while busy is ignored.
- cpu_hold=1 in IDLE, RECV and WRITE; it is 0 only in DONE.
- word_idx never wraps: word_count <= REGSIZE guarantees the last address is at most REGSIZE-1.
- Bytes presented while in_ready=0 are not consumed. Source bytes beyond word_count*4 are never accepted.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3;
  - BYTES_PER_WORD=4;
  - byte-lane index width (2).
- Sub-module imem_word_packer:
  - byte shift/lane register with byte_idx counter;
  - outputs word_full and the assembled word;
  - clear input driven by the FSM.
- Counter, FSM and memory-port registers live in imem_loader.

Test Plan:
1. Basic load: start with word_count=2, then bytes 73 81 20 00 F3 91 20 00 streamed back-to-back -> two single-cycle writes, addr0=0x00208173 then addr1=0x002091F3. Then done=1, cpu_hold=0, busy=0.
2. in_valid gaps: same stream with in_valid toggled 1-0-0-1 between bytes -> identical writes, mem_we high exactly 2 cycles total, no write during gaps.
3. Zero count: start with word_count=0 -> done=1 the next cycle, mem_we never asserted, in_ready never high.
4. Overflow: start with word_count=33 (REGSIZE=32) -> error=1, busy=0, cpu_hold=1, no writes. A following start with word_count=1 clears error and loads addr0.
5. Reset mid-load: rst pulsed asynchronously (between clock edges) after 2 bytes of word 1 -> all outputs at reset values immediately. A new start with word_count=1 and bytes 13 00 00 00 writes addr0=0x00000013.
6. Full depth: word_count=32 with 128 bytes, plus a start pulse injected mid-load -> start ignored, writes to addr 0..31 in order, last write at addr 31 with no wrap, done=1.
